// File: rtl/soc_pkg.sv
// Shared SoC definitions: UART transmitter state encoding and default
// clock / baud constants used by the UART blocks.
package soc_pkg;

    // UART transmitter frame states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DEF_CLK_FREQ_HZ = 12000000;
    localparam int DEF_BAUD_RATE   = 115200;

    // Number of data bits in an 8N1 frame.
    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and raises o_tick for the
// last cycle of each period. i_clear restarts the period from zero so a
// new bit always gets its full width.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Free-running period counter, restarted by clear and at period end.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. Handshake: a byte is accepted on a rising CLK edge
// where tx_valid=1 and tx_ready=1; tx_ready is high only in IDLE, and
// tx_valid while tx_ready=0 is simply ignored (nothing is queued).
// TXD comes straight from a flop that the asynchronous reset forces high.
module uart_tx
    import soc_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int BAUD_RATE   = DEF_BAUD_RATE
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        TXD,
    output uart_state_t o_dbg_state
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
    end

    uart_state_t r_state;
    uart_state_t w_state_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_next;
    logic        r_txd;
    logic        w_txd_next;
    logic        w_clear;
    logic        w_tick;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    // State, shift register, bit index and line flop.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_idx   <= w_idx_next;
            r_txd   <= w_txd_next;
        end
    end

    // Next-state logic; the bit timer is cleared on every transition and
    // held cleared while idle.
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_idx_next   = r_idx;
        w_txd_next   = r_txd;
        w_clear      = 1'b0;
        case (r_state)
            IDLE: begin
                w_clear    = 1'b1;
                w_txd_next = 1'b1;
                w_idx_next = '0;
                if (tx_valid) begin
                    w_state_next = START;
                    w_shift_next = tx_data;
                    w_txd_next   = 1'b0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                    w_idx_next   = '0;
                    w_txd_next   = r_shift[0];
                    w_clear      = 1'b1;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_idx == 3'(UART_DATA_BITS - 1)) begin
                        w_state_next = STOP;
                        w_idx_next   = '0;
                        w_txd_next   = 1'b1;
                        w_clear      = 1'b1;
                    end else begin
                        w_shift_next = r_shift >> 1;
                        w_idx_next   = r_idx + 3'd1;
                        w_txd_next   = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_state_next = IDLE;
                    w_idx_next   = '0;
                    w_txd_next   = 1'b1;
                    w_clear      = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_txd_next   = 1'b1;
                w_clear      = 1'b1;
            end
        endcase
    end

    assign tx_ready    = (r_state == IDLE);
    assign TXD         = r_txd;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 1 MHz / 100 kbaud (10 clocks per bit).
module tb_uart_tx;
    import soc_pkg::*;

    localparam int CPB   = 10;
    localparam int FRAME = 10 * CPB;

    logic        CLK;
    logic        RESET;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        TXD;
    uart_state_t o_dbg_state;

    int n_checks;
    int n_fail;

    uart_tx #(
        .CLK_FREQ_HZ (1000000),
        .BAUD_RATE   (100000)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .TXD         (TXD),
        .o_dbg_state (o_dbg_state)
    );

    // Clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Expected line level for sample i (0..99) of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        int b;
        b = i / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    function automatic uart_state_t exp_state(input int i);
        if (i < CPB)     return START;
        if (i < 9 * CPB) return DATA;
        return STOP;
    endfunction

    // Wait (bounded) for idle, present a byte, and let it be accepted.
    task automatic send(input logic [7:0] d, input logic hold_valid,
                        input logic [7:0] data_after);
        int waited;
        waited = 0;
        @(negedge CLK);
        while (!tx_ready && waited < 300) begin
            @(negedge CLK);
            waited++;
        end
        n_checks++;
        if (!tx_ready) begin
            n_fail++;
            $display("FAIL send_wait: tx_ready=%b required 1 within 300 cycles", tx_ready);
        end
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge CLK);
        #1;
        tx_data = data_after;
        if (!hold_valid) tx_valid = 1'b0;
    endtask

    // Sample a whole frame on negedges after the accept edge; optionally
    // pulse tx_valid at sample pulse_at.
    task automatic check_frame(input logic [7:0] d, input string name,
                               input int pulse_at);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge CLK);
            n_checks++;
            if (TXD !== exp_bit(d, i)) begin
                n_fail++;
                $display("FAIL %s txd[%0d]: got %b required %b", name, i, TXD, exp_bit(d, i));
            end
            n_checks++;
            if (tx_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s ready[%0d]: got %b required 0", name, i, tx_ready);
            end
            n_checks++;
            if (o_dbg_state !== exp_state(i)) begin
                n_fail++;
                $display("FAIL %s state[%0d]: got %0d required %0d", name, i, o_dbg_state, exp_state(i));
            end
            if (pulse_at >= 0 && i == pulse_at) begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
            end else if (pulse_at >= 0 && i == pulse_at + 1) begin
                tx_valid = 1'b0;
            end
        end
    endtask

    // One idle cycle after a frame: line high, ready high.
    task automatic check_idle(input string name);
        @(negedge CLK);
        n_checks++;
        if (TXD !== 1'b1 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle: txd=%b ready=%b required 1 1", name, TXD, tx_ready);
        end
    endtask

    task automatic test_reset();
        RESET    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (TXD !== 1'b1 || tx_ready !== 1'b1 || o_dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_vals: txd=%b ready=%b state=%0d required 1 1 0", TXD, tx_ready, o_dbg_state);
        end
        RESET = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            n_checks++;
            if (TXD !== 1'b1 || tx_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL idle50[%0d]: txd=%b ready=%b required 1 1", i, TXD, tx_ready);
            end
        end
    endtask

    task automatic test_send_55();
        send(8'h55, 1'b0, 8'h55);
        check_frame(8'h55, "send55", -1);
        check_idle("send55");
    endtask

    task automatic test_data_change();
        send(8'hA3, 1'b0, 8'h00);
        check_frame(8'hA3, "datachg", -1);
        check_idle("datachg");
    endtask

    task automatic test_back_to_back();
        send(8'h0F, 1'b1, 8'hF0);
        check_frame(8'h0F, "b2b_first", -1);
        check_idle("b2b_gap");
        @(posedge CLK);
        #1;
        tx_valid = 1'b0;
        check_frame(8'hF0, "b2b_second", -1);
        check_idle("b2b_end");
    endtask

    task automatic test_ignore_mid();
        send(8'h3C, 1'b0, 8'h3C);
        check_frame(8'h3C, "ignore", 29);
        check_idle("ignore");
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            n_checks++;
            if (TXD !== 1'b1 || tx_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL ignore_queued[%0d]: txd=%b ready=%b required 1 1", i, TXD, tx_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        send(8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 45; i++) begin
            @(negedge CLK);
            n_checks++;
            if (TXD !== exp_bit(8'h00, i)) begin
                n_fail++;
                $display("FAIL rstmid txd[%0d]: got %b required %b", i, TXD, exp_bit(8'h00, i));
            end
        end
        RESET = 1'b0;
        #1;
        n_checks++;
        if (TXD !== 1'b1 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_async: txd=%b ready=%b required 1 1", TXD, tx_ready);
        end
        @(negedge CLK);
        n_checks++;
        if (o_dbg_state !== IDLE || TXD !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_held: state=%0d txd=%b required 0 1", o_dbg_state, TXD);
        end
        RESET    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h81;
        @(posedge CLK);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        check_frame(8'h81, "after_rst", -1);
        check_idle("after_rst");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_send_55();
        test_data_change();
        test_back_to_back();
        test_ignore_mid();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 12000000, CLK frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 CLK  input  1  single system clock; all state updates on posedge CLK.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 tx_data  input  8  byte to send; sampled only on the accept cycle.
REQ-006 tx_valid  input  1  requester has a byte on tx_data.
REQ-007 tx_ready  output  1  block can accept a byte this cycle.
REQ-008 TXD  output  1  serial line, idle high.

Function
REQ-009 Frame SHALL be 8N1: start bit (0), data bits LSB first, one stop bit (1); no parity.
REQ-010 CLKS_PER_BIT SHALL equal CLK_FREQ_HZ/BAUD_RATE, integer-truncated; elaboration SHALL fail if CLKS_PER_BIT < 2.
REQ-011 Each bit, including start and stop, SHALL hold TXD for exactly CLKS_PER_BIT cycles.
REQ-012 States SHALL be IDLE, START, DATA, STOP.
REQ-013 tx_ready SHALL be 1 in IDLE and 0 in every other state.
REQ-014 Accept occurs on a posedge with tx_valid=1 and tx_ready=1: tx_data is latched into an 8-bit shift register and the state goes to START.
REQ-015 TXD SHALL go low in the first cycle after the accept edge, giving one cycle of latency.
REQ-016 START -> DATA after CLKS_PER_BIT cycles; the bit index is cleared and TXD = shift[0].
REQ-017 DATA shifts right every CLKS_PER_BIT cycles; after the 8th bit period it goes to STOP.
REQ-018 STOP drives TXD=1 for CLKS_PER_BIT cycles, then goes to IDLE.
REQ-019 The accept-to-TXD-start latency is 1 cycle, and the frame is 10*CLKS_PER_BIT cycles long.
REQ-020 The minimum accept-to-accept spacing is 10*CLKS_PER_BIT+1 cycles.
REQ-021 tx_valid while tx_ready=0 SHALL be ignored; it is not queued and does not disturb the frame.
REQ-022 tx_data changes after the accept cycle SHALL NOT affect the frame in flight.
REQ-023 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide and the bit index 3 bits wide; both SHALL reload on every state transition and never wrap mid-bit.
REQ-024 TXD SHALL be driven from a flop, so it is glitch-free.
REQ-025 tx_valid held high continuously SHALL produce back-to-back frames, each separated by exactly 1 idle-high cycle.

Reset
REQ-026 While RESET=0: state=IDLE, TXD=1, tx_ready=1, counters=0, and the shift register is 0.
REQ-027 RESET asserted mid-frame SHALL force TXD=1 immediately, without waiting for a clock edge, and abort the frame; no partial completion occurs.
REQ-028 On the first posedge after RESET deasserts, an accept is permitted if tx_valid=1.

Structure
REQ-029 The state enum (IDLE/START/DATA/STOP) and the default CLK_FREQ_HZ/BAUD_RATE constants SHALL live in the shared soc_pkg package.
REQ-030 Bit timing SHALL be a sub-module uart_baud_tick (clear input, one-cycle tick output every CLKS_PER_BIT cycles); the FSM and shift register stay in uart_tx.
REQ-031 The SOC top SHALL connect its TXD port to uart_tx.TXD, replacing the constant 0.

Verification (CLK_FREQ_HZ=1000000, BAUD_RATE=100000, CLKS_PER_BIT=10)
REQ-032 Reset then idle 50 cycles -> TXD=1 and tx_ready=1 throughout.
REQ-033 Send 0x55 -> TXD bits 0,1,0,1,0,1,0,1,0,1, each 10 cycles; tx_ready low for exactly 100 cycles.
REQ-034 Send 0xA3 with tx_data changed to 0x00 one cycle after accept -> data bits on TXD are 1,1,0,0,0,1,0,1.
REQ-035 tx_valid held high with 0x0F then 0xF0 -> two correct frames separated by exactly 1 idle-high cycle.
REQ-036 Pulse tx_valid at cycle 30 of a frame -> the pulse is ignored and the frame is unchanged.
REQ-037 Assert RESET at cycle 45 of a 0x00 frame -> TXD=1 with no clock edge, tx_ready=1, and the next send of 0x81 yields a correct full frame.
